mem_arb_rr: RTL and testbench

- N-channel memory request arbiter with round-robin grant, ID allocation and response routing.
- Sits between requesters (IME, DME, future ports) and the pipelined memory model.
- Parametrised successor to the fixed 2-port instruction/data arbiter.
- Adds bounded outstanding-request tracking, per-channel response steering and per-channel flush of in-flight requests.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_picker.sv | 37 +++
 rtl/mem_arb_rr.sv | 177 +++++++++++++++++
 tb/tb_mem_arb_rr.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the memory request arbiters: outstanding-table entry layout
// and a saturating counter helper.
package arb_pkg;

  localparam int ARB_MAX_CH  = 8;
  localparam int ARB_OWNER_W = $clog2(ARB_MAX_CH);

  typedef struct packed {
    logic                   valid;
    logic                   drop;
    logic [ARB_OWNER_W-1:0] owner;
  } arb_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after i_ptr wins,
// wrapping modulo NUM_CH; o_next_ptr is the winner + 1 (held when idle).
module rr_picker #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [PTR_W-1:0]  o_next_ptr,
  output logic              o_valid
);

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_grant    = '0;
    o_next_ptr = i_ptr;
    o_valid    = 1'b0;
    // Upper half of the ring first (channels >= pointer), then wrap around.
    for (int c = 0; c < NUM_CH; c++) begin
      if (!o_valid && i_req[c] && (PTR_W'(c) >= i_ptr)) begin
        o_grant[c] = 1'b1;
        o_valid    = 1'b1;
        o_next_ptr = (c == NUM_CH - 1) ? '0 : PTR_W'(c + 1);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!o_valid && i_req[c]) begin
        o_grant[c] = 1'b1;
        o_valid    = 1'b1;
        o_next_ptr = (c == NUM_CH - 1) ? '0 : PTR_W'(c + 1);
      end
    end
  end

endmodule

// File: rtl/mem_arb_rr.sv
// N-channel round-robin memory arbiter with ID allocation, response routing
// and per-channel flush. Optional perf counters: define ARB_PERF_CNT_EN.
module mem_arb_rr
  import arb_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int PA_WIDTH   = 32,
  parameter int LINE_BYTES = 16,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUT    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CH-1:0]                    i_req_enable,
  input  logic [NUM_CH-1:0]                    i_req_write,
  input  logic [NUM_CH-1:0][PA_WIDTH-1:0]      i_req_addr,
  input  logic [NUM_CH-1:0][LINE_BYTES*8-1:0]  i_req_data,
  input  logic [NUM_CH-1:0]                    i_flush,
  output logic [NUM_CH-1:0]                    o_req_grant,
  output logic [ID_WIDTH-1:0]                  o_req_id,
  output logic                                 o_mem_enable,
  output logic                                 o_mem_write,
  output logic [PA_WIDTH-1:0]                  o_mem_addr,
  output logic [LINE_BYTES*8-1:0]              o_mem_data,
  output logic [ID_WIDTH-1:0]                  o_mem_id,
  input  logic                                 i_mem_full,
  input  logic                                 i_rsp_enable,
  input  logic [ID_WIDTH-1:0]                  i_rsp_id,
  input  logic [LINE_BYTES*8-1:0]              i_rsp_data,
  output logic [NUM_CH-1:0]                    o_rsp_enable,
  output logic [LINE_BYTES*8-1:0]              o_rsp_data,
  output logic [ID_WIDTH-1:0]                  o_rsp_id,
  output logic                                 o_busy,
  output logic                                 o_err_spurious
`ifdef ARB_PERF_CNT_EN
  , output logic [NUM_CH-1:0][31:0]            o_perf_grant
  , output logic [NUM_CH-1:0][31:0]            o_perf_wait
`endif
);

  localparam int PTR_W = $clog2(NUM_CH);

  arb_entry_t          r_table [MAX_OUT];
  logic [PTR_W-1:0]    r_ptr;

  logic [NUM_CH-1:0]   w_req_masked;
  logic [NUM_CH-1:0]   w_pick_grant;
  logic [PTR_W-1:0]    w_next_ptr;
  logic                w_pick_valid;
  logic                w_grant_ok;
  logic [PTR_W-1:0]    w_gnt_ch;
  logic                w_any_free;
  logic [ID_WIDTH-1:0] w_free_id;
  logic [MAX_OUT-1:0]  w_valid_vec;
  logic [MAX_OUT-1:0]  w_flush_hit;
  logic [MAX_OUT-1:0]  w_rsp_free;
  logic                w_spurious;

  assign w_req_masked = i_req_enable & ~i_flush;

  rr_picker #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_picker (
    .i_req      (w_req_masked),
    .i_ptr      (r_ptr),
    .o_grant    (w_pick_grant),
    .o_next_ptr (w_next_ptr),
    .o_valid    (w_pick_valid)
  );

  // Allocation looks only at start-of-cycle valid bits, so an entry freed by
  // this cycle's response is not reissued until the next cycle.
  always_comb begin
    w_any_free  = 1'b0;
    w_free_id   = '0;
    w_valid_vec = '0;
    w_flush_hit = '0;
    for (int e = 0; e < MAX_OUT; e++) begin
      w_valid_vec[e] = r_table[e].valid;
      if (!r_table[e].valid && !w_any_free) begin
        w_any_free = 1'b1;
        w_free_id  = ID_WIDTH'(e);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_table[e].valid && i_flush[c] && (r_table[e].owner == ARB_OWNER_W'(c)))
          w_flush_hit[e] = 1'b1;
      end
    end
  end

  always_comb begin
    w_gnt_ch = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_pick_grant[c]) w_gnt_ch = PTR_W'(c);
    end
  end

  assign w_grant_ok  = w_pick_valid && !i_mem_full && w_any_free;
  assign o_req_grant = w_grant_ok ? w_pick_grant : '0;
  assign o_req_id    = w_free_id;

  // Response steering; dropped entries and entries flushed this cycle are
  // freed silently, IDs with no valid entry (including >= MAX_OUT) are spurious.
  always_comb begin
    w_rsp_free   = '0;
    o_rsp_enable = '0;
    w_spurious   = i_rsp_enable;
    for (int e = 0; e < MAX_OUT; e++) begin
      if (i_rsp_enable && (i_rsp_id == ID_WIDTH'(e)) && r_table[e].valid) begin
        w_rsp_free[e] = 1'b1;
        w_spurious    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          if ((r_table[e].owner == ARB_OWNER_W'(c)) && !r_table[e].drop && !w_flush_hit[e])
            o_rsp_enable[c] = 1'b1;
        end
      end
    end
  end

  assign o_rsp_data = i_rsp_data;
  assign o_rsp_id   = i_rsp_id;
  assign o_busy     = |w_valid_vec;

  // NOTE: the table is a handful of flops whose valid bits gate allocation,
  // so it must be reset; a RAM-style unreset array would start with garbage IDs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < MAX_OUT; e++) r_table[e] <= '0;
    end else begin
      for (int e = 0; e < MAX_OUT; e++) begin
        if (w_flush_hit[e]) r_table[e].drop  <= 1'b1;
        if (w_rsp_free[e])  r_table[e].valid <= 1'b0;
        if (w_grant_ok && (w_free_id == ID_WIDTH'(e)))
          r_table[e] <= '{valid: 1'b1, drop: 1'b0, owner: ARB_OWNER_W'(w_gnt_ch)};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples start-of-cycle values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr          <= '0;
      o_mem_enable   <= 1'b0;
      o_mem_write    <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_data     <= '0;
      o_mem_id       <= '0;
      o_err_spurious <= 1'b0;
    end else begin
      o_mem_enable <= w_grant_ok;
      if (w_grant_ok) begin
        r_ptr       <= w_next_ptr;
        o_mem_write <= i_req_write[w_gnt_ch];
        o_mem_addr  <= i_req_addr[w_gnt_ch];
        o_mem_data  <= i_req_data[w_gnt_ch];
        o_mem_id    <= w_free_id;
      end
      if (w_spurious) o_err_spurious <= 1'b1;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_perf_grant <= '0;
      o_perf_wait  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (o_req_grant[c])
          o_perf_grant[c] <= sat_inc32(o_perf_grant[c]);
        else if (i_req_enable[c])
          o_perf_wait[c] <= sat_inc32(o_perf_wait[c]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arb_rr.sv
// Directed self-checking bench for mem_arb_rr (3 channels, 4 outstanding IDs)
// with a scoreboard queue of expected memory-side transactions.
module tb_mem_arb_rr;

  localparam int NUM_CH = 3;
  localparam int PA_W   = 32;
  localparam int LB     = 16;
  localparam int DW     = LB * 8;
  localparam int IDW    = 4;
  localparam int MO     = 4;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NUM_CH-1:0]              i_req_enable;
  logic [NUM_CH-1:0]              i_req_write;
  logic [NUM_CH-1:0][PA_W-1:0]    i_req_addr;
  logic [NUM_CH-1:0][DW-1:0]      i_req_data;
  logic [NUM_CH-1:0]              i_flush;
  logic [NUM_CH-1:0]              o_req_grant;
  logic [IDW-1:0]                 o_req_id;
  logic                           o_mem_enable;
  logic                           o_mem_write;
  logic [PA_W-1:0]                o_mem_addr;
  logic [DW-1:0]                  o_mem_data;
  logic [IDW-1:0]                 o_mem_id;
  logic                           i_mem_full;
  logic                           i_rsp_enable;
  logic [IDW-1:0]                 i_rsp_id;
  logic [DW-1:0]                  i_rsp_data;
  logic [NUM_CH-1:0]              o_rsp_enable;
  logic [DW-1:0]                  o_rsp_data;
  logic [IDW-1:0]                 o_rsp_id;
  logic                           o_busy;
  logic                           o_err_spurious;
`ifdef ARB_PERF_CNT_EN
  logic [NUM_CH-1:0][31:0]        o_perf_grant;
  logic [NUM_CH-1:0][31:0]        o_perf_wait;
`endif

  mem_arb_rr #(
    .NUM_CH(NUM_CH), .PA_WIDTH(PA_W), .LINE_BYTES(LB), .ID_WIDTH(IDW), .MAX_OUT(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_enable(i_req_enable), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_flush(i_flush),
    .o_req_grant(o_req_grant), .o_req_id(o_req_id),
    .o_mem_enable(o_mem_enable), .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .o_mem_id(o_mem_id), .i_mem_full(i_mem_full),
    .i_rsp_enable(i_rsp_enable), .i_rsp_id(i_rsp_id), .i_rsp_data(i_rsp_data),
    .o_rsp_enable(o_rsp_enable), .o_rsp_data(o_rsp_data), .o_rsp_id(o_rsp_id),
    .o_busy(o_busy), .o_err_spurious(o_err_spurious)
`ifdef ARB_PERF_CNT_EN
    , .o_perf_grant(o_perf_grant), .o_perf_wait(o_perf_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            wr;
    logic [PA_W-1:0] addr;
    logic [DW-1:0]   data;
    logic [IDW-1:0]  id;
  } mem_tx_t;

  mem_tx_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant to channel ch with ID id is expected now; queue the memory-side copy.
  task automatic expect_grant(input int ch, input int id);
    mem_tx_t tx;
    check($sformatf("grant_ch%0d", ch), DW'(o_req_grant), DW'(1 << ch));
    check($sformatf("req_id_ch%0d", ch), DW'(o_req_id), DW'(id));
    tx.wr   = i_req_write[ch];
    tx.addr = i_req_addr[ch];
    tx.data = i_req_data[ch];
    tx.id   = IDW'(id);
    exp_q.push_back(tx);
  endtask

  task automatic expect_mem();
    mem_tx_t tx;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL mem_queue observed=empty expected=entry");
    end else begin
      tx = exp_q.pop_front();
      check("mem_enable", DW'(o_mem_enable), DW'(1'b1));
      check("mem_write",  DW'(o_mem_write),  DW'(tx.wr));
      check("mem_addr",   DW'(o_mem_addr),   DW'(tx.addr));
      check("mem_data",   o_mem_data,        tx.data);
      check("mem_id",     DW'(o_mem_id),     DW'(tx.id));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain_id [4] = '{2, 0, 3, 1};
    int drain_own[4] = '{2, 0, 0, 1};

    rst = 1'b0;
    i_req_enable = '0; i_req_write = 3'b010; i_flush = '0;
    i_mem_full = 1'b0; i_rsp_enable = 1'b0; i_rsp_id = '0;
    i_rsp_data = {4{32'hC0DE_F00D}};
    for (int c = 0; c < NUM_CH; c++) begin
      i_req_addr[c] = 32'h1000 + 32'(c) * 32'h40;
      i_req_data[c] = {4{32'hA000_0000 + 32'(c)}};
    end

    // Reset state
    @(negedge clk);
    check("rst_mem_enable", DW'(o_mem_enable), '0);
    check("rst_mem_addr",   DW'(o_mem_addr),   '0);
    check("rst_busy",       DW'(o_busy),       '0);
    check("rst_spurious",   DW'(o_err_spurious), '0);
    tick();
    rst = 1'b1;

    // Round robin across all three channels, IDs 0..3 fill the table
    i_req_enable = 3'b111;
    @(negedge clk); expect_grant(0, 0); tick();
    @(negedge clk); expect_mem(); expect_grant(1, 1); tick();
    @(negedge clk); expect_mem(); expect_grant(2, 2); tick();
    @(negedge clk); expect_mem(); expect_grant(0, 3);
    check("busy_filled", DW'(o_busy), DW'(1'b1)); tick();
    @(negedge clk); expect_mem();
    check("full_no_grant", DW'(o_req_grant), '0); tick();

    // Response frees ID 1, but the slot is only reusable next cycle
    i_rsp_enable = 1'b1; i_rsp_id = 4'd1;
    @(negedge clk);
    check("rsp_route_id1", DW'(o_rsp_enable), DW'(3'b010));
    check("rsp_data_pass", o_rsp_data, {4{32'hC0DE_F00D}});
    check("full_same_cycle_free", DW'(o_req_grant), '0);
    check("mem_idle", DW'(o_mem_enable), '0); tick();
    i_rsp_enable = 1'b0;
    @(negedge clk); expect_grant(1, 1); tick();
    i_req_enable = '0;
    @(negedge clk); expect_mem(); tick();

    // Drain in a scrambled order
    for (int i = 0; i < 4; i++) begin
      i_rsp_enable = 1'b1; i_rsp_id = IDW'(drain_id[i]);
      @(negedge clk);
      check($sformatf("drain_id%0d", drain_id[i]), DW'(o_rsp_enable), DW'(1 << drain_own[i]));
      tick();
    end
    i_rsp_enable = 1'b0;
    @(negedge clk); check("busy_drained", DW'(o_busy), '0); tick();

    // Backpressure: three full cycles, grant on the fourth
    i_req_enable = 3'b001; i_req_addr[0] = 32'h100; i_req_write[0] = 1'b0; i_mem_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_no_grant", DW'(o_req_grant), '0);
      check("bp_mem_idle", DW'(o_mem_enable), '0);
      tick();
    end
    i_mem_full = 1'b0;
    @(negedge clk); expect_grant(0, 0); tick();
    i_req_enable = '0;
    @(negedge clk); expect_mem();
    check("bp_addr", DW'(o_mem_addr), DW'(32'h100)); tick();
    i_rsp_enable = 1'b1; i_rsp_id = 4'd0;
    @(negedge clk); check("bp_rsp", DW'(o_rsp_enable), DW'(3'b001)); tick();
    i_rsp_enable = 1'b0;

    // Flush of ch0 with ID 0 in flight, request masked during flush
    i_req_enable = 3'b001;
    @(negedge clk); expect_grant(0, 0); tick();
    i_flush = 3'b001;
    @(negedge clk); expect_mem();
    check("flush_masks_req", DW'(o_req_grant), '0); tick();
    i_flush = '0; i_req_enable = '0; i_rsp_enable = 1'b1; i_rsp_id = 4'd0;
    @(negedge clk);
    check("flush_rsp_dropped", DW'(o_rsp_enable), '0);
    check("flush_busy_before_free", DW'(o_busy), DW'(1'b1)); tick();
    i_rsp_enable = 1'b0;
    @(negedge clk); check("flush_busy_clear", DW'(o_busy), '0); tick();

    // Flush and response for the same entry in one cycle
    i_req_enable = 3'b100;
    @(negedge clk); expect_grant(2, 0); tick();
    i_req_enable = '0; i_flush = 3'b100; i_rsp_enable = 1'b1; i_rsp_id = 4'd0;
    @(negedge clk); expect_mem();
    check("flush_same_cycle_rsp", DW'(o_rsp_enable), '0); tick();
    i_flush = '0; i_rsp_enable = 1'b0;
    @(negedge clk);
    check("flush_same_busy", DW'(o_busy), '0);
    check("no_spurious_yet", DW'(o_err_spurious), '0); tick();

    // Spurious response to ID 5 (beyond MAX_OUT, nothing outstanding)
    i_rsp_enable = 1'b1; i_rsp_id = 4'd5;
    @(negedge clk); check("spur_no_route", DW'(o_rsp_enable), '0); tick();
    i_rsp_enable = 1'b0;
    @(negedge clk); check("spur_set", DW'(o_err_spurious), DW'(1'b1)); tick();
    tick();
    @(negedge clk); check("spur_sticky", DW'(o_err_spurious), DW'(1'b1)); tick();

    // Reset mid-operation with three entries valid and a memory request out
    i_req_enable = 3'b111;
    @(negedge clk); expect_grant(0, 0); tick();
    @(negedge clk); expect_mem(); expect_grant(1, 1); tick();
    @(negedge clk); expect_mem(); expect_grant(2, 2); tick();
    i_req_enable = '0;
    expect_mem();
    rst = 1'b0;
    #1;
    check("arst_mem_enable", DW'(o_mem_enable), '0);
    check("arst_mem_addr",   DW'(o_mem_addr),   '0);
    check("arst_mem_id",     DW'(o_mem_id),     '0);
    check("arst_busy",       DW'(o_busy),       '0);
    check("arst_spurious",   DW'(o_err_spurious), '0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    i_req_enable = 3'b111;
    @(negedge clk); expect_grant(0, 0); tick();
    i_req_enable = '0;
    @(negedge clk); expect_mem(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
